// File: rtl/multi_timer.sv
// Multi-channel down-counter timer with per-channel prescaler, sticky pending flag and combined IRQ.
// Register writes take effect on the next clock edge; read data and IRQ are combinational from registered state.
// No backpressure: every register access completes in the cycle it is presented.
module multi_timer #(
  parameter int CH_BITS = 1,
  parameter int WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CH_BITS+3:2]   addr,
  input  logic                 we,
  input  logic [31:0]          datain,
  output logic [31:0]          dataout,
  output logic                 IRQ
);

  localparam int NUM_CH = 2 ** CH_BITS;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL layout: [0] EN, [2:1] MODE, [3] IM, [7:4] PSC
  logic [7:0]       ctrl    [NUM_CH];
  logic [WIDTH-1:0] preset  [NUM_CH];
  logic [WIDTH-1:0] count   [NUM_CH];
  logic [3:0]       psc_cnt [NUM_CH];
  logic [NUM_CH-1:0] pend;

  logic [CH_BITS-1:0] sel_ch;
  logic [1:0]         sel_reg;

  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_preset;
  logic [NUM_CH-1:0] wr_status;
  logic [NUM_CH-1:0] dec;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] auto_rl;
  logic [NUM_CH-1:0] irq_vec;

  assign sel_ch  = addr[CH_BITS+3:4];
  assign sel_reg = addr[3:2];

  // Decode per-channel write strobes, decrement ticks, expiry and masked interrupt.
  always_comb begin
    wr_ctrl   = '0;
    wr_preset = '0;
    wr_status = '0;
    dec       = '0;
    expire    = '0;
    auto_rl   = '0;
    irq_vec   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ctrl[i]   = we && (sel_ch == CH_BITS'(i)) && (sel_reg == REG_CTRL);
      wr_preset[i] = we && (sel_ch == CH_BITS'(i)) && (sel_reg == REG_PRESET);
      wr_status[i] = we && (sel_ch == CH_BITS'(i)) && (sel_reg == REG_STATUS);
      auto_rl[i]   = (ctrl[i][2:1] == 2'b01);
      dec[i]       = ctrl[i][0] && (count[i] != '0) && (psc_cnt[i] == ctrl[i][7:4]);
      // A CPU write to CTRL/PRESET pre-empts counting, so it also suppresses expiry.
      expire[i]    = dec[i] && (count[i] == WIDTH'(1)) && !wr_ctrl[i] && !wr_preset[i];
      irq_vec[i]   = pend[i] && ctrl[i][3];
    end
  end

  // Per-channel control, preset, counter and prescaler state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ctrl[i]    <= '0;
        preset[i]  <= '0;
        count[i]   <= '0;
        psc_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_preset[i]) begin
          preset[i]  <= datain[WIDTH-1:0];
          count[i]   <= datain[WIDTH-1:0];
          psc_cnt[i] <= '0;
        end else if (wr_ctrl[i]) begin
          ctrl[i]    <= datain[7:0];
          psc_cnt[i] <= '0;
        end else if (ctrl[i][0]) begin
          if (count[i] != '0) begin
            if (dec[i]) begin
              psc_cnt[i] <= '0;
              count[i]   <= count[i] - WIDTH'(1);
              // One-shot (and the reserved modes) disarm on expiry.
              if (expire[i] && !auto_rl[i]) ctrl[i][0] <= 1'b0;
            end else begin
              psc_cnt[i] <= psc_cnt[i] + 4'd1;
            end
          end else if (auto_rl[i]) begin
            // Reload the cycle after reaching zero; PRESET=0 keeps reloading zero, i.e. idles.
            count[i]   <= preset[i];
            psc_cnt[i] <= '0;
          end
        end
      end
    end
  end

  // Sticky pending flags: expiry set beats a simultaneous software clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (expire[i]) begin
          pend[i] <= 1'b1;
        end else if (wr_status[i] && datain[0]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Read mux for the addressed channel register, zero-extended to 32 bits.
  always_comb begin
    dataout = '0;
    case (sel_reg)
      REG_CTRL:   dataout[7:0]       = ctrl[sel_ch];
      REG_PRESET: dataout[WIDTH-1:0] = preset[sel_ch];
      REG_COUNT:  dataout[WIDTH-1:0] = count[sel_ch];
      REG_STATUS: dataout[0]         = pend[sel_ch];
      default:    dataout            = '0;
    endcase
  end

  assign IRQ = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: two channels, 32-bit counters.
// Inputs change 1 time unit after the rising edge; outputs are sampled within that same low-risk window.
// No backpressure in the DUT; every step is a fixed number of cycles.
module tb_multi_timer;

  localparam int CH_BITS = 1;
  localparam int WIDTH   = 32;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_PRESET = 2'd1;
  localparam logic [1:0] R_COUNT  = 2'd2;
  localparam logic [1:0] R_STATUS = 2'd3;

  logic               clk = 1'b0;
  logic               reset;
  logic [CH_BITS+3:2] addr;
  logic               we;
  logic [31:0]        datain;
  logic [31:0]        dataout;
  logic               IRQ;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  multi_timer #(.CH_BITS(CH_BITS), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .datain  (datain),
    .dataout (dataout),
    .IRQ     (IRQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [CH_BITS-1:0] ch, input logic [1:0] r, input logic [31:0] d);
    addr   = {ch, r};
    datain = d;
    we     = 1'b1;
    @(posedge clk);
    #1;
    we     = 1'b0;
    datain = '0;
  endtask

  task automatic chk_reg(input string tag, input logic [CH_BITS-1:0] ch, input logic [1:0] r,
                         input logic [31:0] exp);
    addr = {ch, r};
    #1;
    check(tag, dataout, exp);
  endtask

  initial begin
    reset  = 1'b1;
    we     = 1'b0;
    addr   = '0;
    datain = '0;
    cyc();
    cyc();
    reset = 1'b0;

    // Reset state
    chk_reg("rst_ctrl0", 1'b0, R_CTRL, 32'h0);
    chk_reg("rst_preset0", 1'b0, R_PRESET, 32'h0);
    chk_reg("rst_count1", 1'b1, R_COUNT, 32'h0);
    check("rst_irq", {31'b0, IRQ}, 32'h0);

    // 1: one-shot, PSC=0; upper CTRL write bits are dropped
    wr(1'b0, R_PRESET, 32'd5);
    wr(1'b0, R_CTRL, 32'hABCD_0009);
    chk_reg("t1_ctrl", 1'b0, R_CTRL, 32'h09);
    for (int k = 5; k >= 0; k--) begin
      if (k != 5) cyc();
      chk_reg("t1_count", 1'b0, R_COUNT, k);
      check("t1_irq", {31'b0, IRQ}, (k == 0) ? 32'h1 : 32'h0);
    end
    chk_reg("t1_pend", 1'b0, R_STATUS, 32'h1);
    chk_reg("t1_en_off", 1'b0, R_CTRL, 32'h08);
    cyc();
    chk_reg("t1_count_hold", 1'b0, R_COUNT, 32'h0);
    check("t1_irq_hold", {31'b0, IRQ}, 32'h1);
    wr(1'b0, R_STATUS, 32'h1);
    chk_reg("t1_clr", 1'b0, R_STATUS, 32'h0);
    check("t1_irq_clr", {31'b0, IRQ}, 32'h0);

    // 2: auto-reload on ch1, period 4
    wr(1'b1, R_PRESET, 32'd3);
    wr(1'b1, R_CTRL, 32'h0B);
    for (int j = 0; j < 8; j++) begin
      if (j != 0) cyc();
      chk_reg("t2_count", 1'b1, R_COUNT, 3 - (j % 4));
      chk_reg("t2_pend", 1'b1, R_STATUS, (j >= 3) ? 32'h1 : 32'h0);
      check("t2_irq", {31'b0, IRQ}, (j >= 3) ? 32'h1 : 32'h0);
    end
    wr(1'b1, R_STATUS, 32'h1);
    chk_reg("t2_reload", 1'b1, R_COUNT, 32'd3);
    chk_reg("t2_clr", 1'b1, R_STATUS, 32'h0);
    for (int j = 1; j <= 3; j++) begin
      cyc();
      chk_reg("t2b_count", 1'b1, R_COUNT, 3 - j);
      chk_reg("t2b_pend", 1'b1, R_STATUS, (j == 3) ? 32'h1 : 32'h0);
    end
    wr(1'b1, R_CTRL, 32'h00);
    wr(1'b1, R_STATUS, 32'h1);
    chk_reg("t2_stop_count", 1'b1, R_COUNT, 32'h0);
    check("t2_irq_off", {31'b0, IRQ}, 32'h0);

    // 3: prescaler 3 -> each value held 4 cycles
    wr(1'b0, R_PRESET, 32'd2);
    wr(1'b0, R_CTRL, 32'h39);
    for (int c = 0; c <= 8; c++) begin
      if (c != 0) cyc();
      chk_reg("t3_count", 1'b0, R_COUNT, (c < 4) ? 32'd2 : (c < 8) ? 32'd1 : 32'd0);
      check("t3_irq", {31'b0, IRQ}, (c == 8) ? 32'h1 : 32'h0);
    end
    chk_reg("t3_ctrl", 1'b0, R_CTRL, 32'h38);

    // 4: both channels expire; clear of ch0 coincides with its expiry
    wr(1'b0, R_STATUS, 32'h1);
    check("t4_irq_pre", {31'b0, IRQ}, 32'h0);
    wr(1'b1, R_PRESET, 32'd3);
    wr(1'b1, R_CTRL, 32'h0B);
    wr(1'b0, R_PRESET, 32'd2);
    wr(1'b0, R_CTRL, 32'h09);
    cyc();
    chk_reg("t4_count0", 1'b0, R_COUNT, 32'd1);
    chk_reg("t4_pend1", 1'b1, R_STATUS, 32'h1);
    wr(1'b0, R_STATUS, 32'h1);
    chk_reg("t4_set_wins", 1'b0, R_STATUS, 32'h1);
    chk_reg("t4_count0_zero", 1'b0, R_COUNT, 32'h0);
    check("t4_irq_both", {31'b0, IRQ}, 32'h1);
    wr(1'b1, R_CTRL, 32'h00);
    wr(1'b1, R_STATUS, 32'h1);
    chk_reg("t4_pend1_clr", 1'b1, R_STATUS, 32'h0);
    check("t4_irq_ch0_only", {31'b0, IRQ}, 32'h1);
    wr(1'b0, R_STATUS, 32'h1);
    check("t4_irq_none", {31'b0, IRQ}, 32'h0);

    // 5: masked interrupt, then unmask
    wr(1'b0, R_CTRL, 32'h01);
    cyc();
    chk_reg("t5_idle_pend", 1'b0, R_STATUS, 32'h0);
    chk_reg("t5_idle_ctrl", 1'b0, R_CTRL, 32'h01);
    wr(1'b0, R_PRESET, 32'd2);
    for (int c = 0; c <= 2; c++) begin
      if (c != 0) cyc();
      chk_reg("t5_count", 1'b0, R_COUNT, 2 - c);
      check("t5_irq_masked", {31'b0, IRQ}, 32'h0);
    end
    chk_reg("t5_pend", 1'b0, R_STATUS, 32'h1);
    wr(1'b0, R_CTRL, 32'h08);
    check("t5_irq_unmask", {31'b0, IRQ}, 32'h1);
    chk_reg("t5_pend_kept", 1'b0, R_STATUS, 32'h1);

    // Auto-reload with PRESET=0 stays idle
    wr(1'b1, R_PRESET, 32'd0);
    wr(1'b1, R_CTRL, 32'h0B);
    cyc();
    cyc();
    cyc();
    chk_reg("t5_zero_count", 1'b1, R_COUNT, 32'h0);
    chk_reg("t5_zero_pend", 1'b1, R_STATUS, 32'h0);
    wr(1'b1, R_CTRL, 32'h00);

    // 6: mid-count preset rewrite, ignored COUNT write, reset
    wr(1'b0, R_PRESET, 32'd6);
    wr(1'b0, R_CTRL, 32'h09);
    chk_reg("t6_count6", 1'b0, R_COUNT, 32'd6);
    cyc();
    cyc();
    chk_reg("t6_count4", 1'b0, R_COUNT, 32'd4);
    wr(1'b0, R_PRESET, 32'd7);
    chk_reg("t6_rewrite", 1'b0, R_COUNT, 32'd7);
    wr(1'b0, R_COUNT, 32'h55);
    chk_reg("t6_count_ro", 1'b0, R_COUNT, 32'd6);
    chk_reg("t6_preset", 1'b0, R_PRESET, 32'd7);
    cyc();
    cyc();
    cyc();
    chk_reg("t6_count3", 1'b0, R_COUNT, 32'd3);
    check("t6_irq_pre", {31'b0, IRQ}, 32'h1);
    addr   = {1'b0, R_PRESET};
    datain = 32'h1234;
    we     = 1'b1;
    reset  = 1'b1;
    cyc();
    reset  = 1'b0;
    we     = 1'b0;
    datain = '0;
    chk_reg("t6_rst_count", 1'b0, R_COUNT, 32'h0);
    chk_reg("t6_rst_preset", 1'b0, R_PRESET, 32'h0);
    chk_reg("t6_rst_ctrl", 1'b0, R_CTRL, 32'h0);
    chk_reg("t6_rst_pend", 1'b0, R_STATUS, 32'h0);
    check("t6_rst_irq", {31'b0, IRQ}, 32'h0);
    cyc();
    chk_reg("t6_rst_hold", 1'b0, R_COUNT, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
